// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one memory port.
// Data wins by default; a saturating starvation counter bounds how long a fetch can wait.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done
);

    localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp
    } stateT;

    stateT            stateQ, stateD;
    logic [CntW-1:0]  starveCntQ, starveCntD;
    logic             iDoneQ, iDoneD;
    logic             dDoneQ, dDoneD;
    logic             dErrQ, dErrD;
    logic             memEnQ, memEnD;
    logic             memWrQ, memWrD;
    logic [15:0]      memAddrQ, memAddrD;
    logic [15:0]      memWdataQ, memWdataD;
    logic [15:0]      iRdataQ, iRdataD;
    logic [15:0]      dRdataQ, dRdataD;
    logic             iWins;
    logic             dWins;
    logic             memAck;

    assign iWins = i_req && (!d_req || (starveCntQ == CntMax));
    assign dWins = d_req && !iWins;

    // Memory latency is at least one cycle, so a completion in the launch cycle is stale.
    assign memAck = mem_done && !memEnQ;

    always_comb begin
        stateD     = stateQ;
        starveCntD = starveCntQ;
        iDoneD     = 1'b0;
        dDoneD     = 1'b0;
        dErrD      = 1'b0;
        memEnD     = 1'b0;
        memWrD     = memWrQ;
        memAddrD   = memAddrQ;
        memWdataD  = memWdataQ;
        iRdataD    = iRdataQ;
        dRdataD    = dRdataQ;

        unique case (stateQ)
            StIdle: begin
                if (!i_req) begin
                    starveCntD = '0;
                end
                if (iWins) begin
                    stateD     = StBusyI;
                    starveCntD = '0;
                    memEnD     = 1'b1;
                    memWrD     = 1'b0;
                    memAddrD   = {i_addr[15:1], 1'b0};
                    memWdataD  = '0;
                end else if (dWins) begin
                    if (i_req && (starveCntQ != CntMax)) begin
                        starveCntD = starveCntQ + 1'b1;
                    end
                    if (d_addr[0]) begin
                        // Misaligned data access completes with an error, never touching memory.
                        stateD = StResp;
                        dDoneD = 1'b1;
                        dErrD  = 1'b1;
                    end else begin
                        stateD    = StBusyD;
                        memEnD    = 1'b1;
                        memWrD    = d_wr;
                        memAddrD  = d_addr;
                        memWdataD = d_wdata;
                    end
                end
            end
            StBusyI: begin
                if (memAck) begin
                    stateD  = StResp;
                    iRdataD = mem_rdata;
                    iDoneD  = 1'b1;
                end
            end
            StBusyD: begin
                if (memAck) begin
                    stateD = StResp;
                    dDoneD = 1'b1;
                    if (!memWrQ) begin
                        dRdataD = mem_rdata;
                    end
                end
            end
            StResp: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            starveCntQ <= '0;
            iDoneQ     <= 1'b0;
            dDoneQ     <= 1'b0;
            dErrQ      <= 1'b0;
            memEnQ     <= 1'b0;
            memWrQ     <= 1'b0;
            memAddrQ   <= '0;
            memWdataQ  <= '0;
            iRdataQ    <= '0;
            dRdataQ    <= '0;
        end else begin
            stateQ     <= stateD;
            starveCntQ <= starveCntD;
            iDoneQ     <= iDoneD;
            dDoneQ     <= dDoneD;
            dErrQ      <= dErrD;
            memEnQ     <= memEnD;
            memWrQ     <= memWrD;
            memAddrQ   <= memAddrD;
            memWdataQ  <= memWdataD;
            iRdataQ    <= iRdataD;
            dRdataQ    <= dRdataD;
        end
    end

    assign i_done    = iDoneQ;
    assign i_rdata   = iRdataQ;
    assign d_done    = dDoneQ;
    assign d_rdata   = dRdataQ;
    assign d_err     = dErrQ;
    assign mem_en    = memEnQ;
    assign mem_wr    = memWrQ;
    assign mem_addr  = memAddrQ;
    assign mem_wdata = memWdataQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requester agents, a latency-randomised memory responder and a
// transaction-level reference model that predicts every output cycle by cycle.
module tb_mem_arbiter;

    localparam int Limit = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req, d_req, d_wr, mem_done;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_done, d_done, d_err, mem_en, mem_wr;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(Limit)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done)
    );

    typedef struct {
        logic [15:0] addr;
        logic        wr;
        logic [15:0] wdata;
        bit          drop;
        int          delay;
    } reqT;

    int tests = 0;
    int failed = 0;
    int cycle = 0;

    reqT iQ[$];
    reqT dQ[$];
    reqT iCur, dCur;
    bit  iActive, dActive, iGranted, dGranted;
    int  dRaiseCycle, dDoneCycle;

    // Reference model: arbiter free/busy, starvation count, in-flight owner, held read data.
    bit          mFree;
    int          mStarve;
    int          mInFlight;
    bit          mInWr;
    logic [15:0] mIR, mDR;
    bit          pMemEn, pWr, pChkWdata, pIDone, pDDone, pDErr;
    logic [15:0] pAddr, pWdata;

    bit          rBusy, rStale, rWr;
    int          rWait, latFix, rstHold;
    logic [15:0] rAddr, rWdata;
    logic [15:0] mem [0:255];

    logic [15:0] addrLog[$], wrLog[$], wdataLog[$], doneLog[$];
    int          cntMemEn, cntIDone, cntDDone, cntDErr;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] qAt(input logic [15:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 16'hxxxx;
    endfunction

    function automatic reqT mk(input logic [15:0] a, input logic w, input logic [15:0] wd,
                               input bit drop, input int delay);
        reqT r;
        r.addr = a; r.wr = w; r.wdata = wd; r.drop = drop; r.delay = delay;
        return r;
    endfunction

    task automatic clearLogs();
        addrLog.delete(); wrLog.delete(); wdataLog.delete(); doneLog.delete();
        cntMemEn = 0; cntIDone = 0; cntDDone = 0; cntDErr = 0;
    endtask

    task automatic tick();
        bit eI, eD;
        @(posedge clk); #1;
        cycle++;
        chk1("mem_en", mem_en, pMemEn);
        chk1("i_done", i_done, pIDone);
        chk1("d_done", d_done, pDDone);
        chk1("d_err", d_err, pDErr);
        chk("i_rdata", i_rdata, mIR);
        chk("d_rdata", d_rdata, mDR);
        if (pMemEn) begin
            chk("grant_addr", mem_addr, pAddr);
            chk1("grant_wr", mem_wr, pWr);
            if (pChkWdata) chk("grant_wdata", mem_wdata, pWdata);
        end
        if (rst) begin
            chk("rst_mem_addr", mem_addr, 16'h0);
            chk("rst_mem_wdata", mem_wdata, 16'h0);
            chk1("rst_mem_wr", mem_wr, 1'b0);
        end
        if (mem_en) begin
            cntMemEn++; addrLog.push_back(mem_addr); wrLog.push_back({15'd0, mem_wr});
            wdataLog.push_back(mem_wdata);
        end
        if (i_done) begin cntIDone++; doneLog.push_back(16'd1); end
        if (d_done) begin cntDDone++; doneLog.push_back(16'd0); dDoneCycle = cycle; end
        if (d_err) cntDErr++;
        eI = pIDone; eD = pDDone;
        pMemEn = 0; pIDone = 0; pDDone = 0; pDErr = 0; pChkWdata = 0;

        // Memory responder
        mem_done = 1'b0;
        if (rBusy) begin
            if (!rStale && !rst) begin
                chk("hold_addr", mem_addr, rAddr);
                chk1("hold_wr", mem_wr, rWr);
                chk("hold_wdata", mem_wdata, rWdata);
            end
            if (rWait == 0) begin
                rBusy = 0;
                mem_done = 1'b1;
                if (rWr) begin
                    mem[rAddr[8:1]] = rWdata;
                    mem_rdata = 16'($urandom);
                end else begin
                    mem_rdata = mem[rAddr[8:1]];
                end
                if (mInFlight == 1) begin pIDone = 1; mIR = mem_rdata; end
                else if (mInFlight == 2) begin pDDone = 1; if (!mInWr) mDR = mem_rdata; end
                mInFlight = 0;
            end else begin
                rWait--;
            end
        end else if (mem_en) begin
            rBusy = 1; rStale = 0;
            rAddr = mem_addr; rWr = mem_wr; rWdata = mem_wdata;
            rWait = (latFix != 0) ? latFix - 1 : int'($urandom_range(3, 0));
        end

        if (rstHold > 0) begin
            rstHold--;
            if (rstHold == 0) rst = 1'b0;
        end

        // Requester agents
        if (!rst) begin
            if (eI) begin iActive = 0; i_req = 0; end
            if (eD) begin dActive = 0; d_req = 0; end
            if (iActive && iGranted && iCur.drop) begin i_req = 0; i_addr = 16'($urandom); end
            if (dActive && dGranted && dCur.drop) begin
                d_req = 0; d_addr = 16'($urandom); d_wdata = 16'($urandom); d_wr = 1'($urandom);
            end
            if (!iActive && iQ.size() > 0) begin
                if (iQ[0].delay > 0) iQ[0].delay = iQ[0].delay - 1;
                else begin
                    iCur = iQ.pop_front(); iActive = 1; iGranted = 0;
                    i_req = 1; i_addr = iCur.addr;
                end
            end
            if (!dActive && dQ.size() > 0) begin
                if (dQ[0].delay > 0) dQ[0].delay = dQ[0].delay - 1;
                else begin
                    dCur = dQ.pop_front(); dActive = 1; dGranted = 0; dRaiseCycle = cycle;
                    d_req = 1; d_wr = dCur.wr; d_addr = dCur.addr; d_wdata = dCur.wdata;
                end
            end
        end

        // Arbitration decision for this cycle, visible next cycle
        if (!rst && mFree) begin
            if (!i_req) mStarve = 0;
            if (i_req || d_req) begin
                if (i_req && (!d_req || mStarve == Limit)) begin
                    pMemEn = 1; pAddr = {i_addr[15:1], 1'b0}; pWr = 0;
                    mInFlight = 1; mStarve = 0; iGranted = 1;
                end else begin
                    if (i_req) mStarve = (mStarve < Limit) ? mStarve + 1 : Limit;
                    dGranted = 1;
                    if (d_addr[0]) begin
                        pDDone = 1; pDErr = 1;
                    end else begin
                        pMemEn = 1; pAddr = d_addr; pWr = d_wr; pWdata = d_wdata; pChkWdata = 1;
                        mInFlight = 2; mInWr = d_wr;
                    end
                end
                mFree = 0;
            end
        end
        if (eI || eD) mFree = 1;
    endtask

    task automatic doReset(input int holdCycles);
        rst = 1'b1;
        #1;
        chk1("rst_i_done", i_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk1("rst_d_err", d_err, 1'b0);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_mem_wr_async", mem_wr, 1'b0);
        chk("rst_mem_addr_async", mem_addr, 16'h0);
        chk("rst_mem_wdata_async", mem_wdata, 16'h0);
        chk("rst_i_rdata", i_rdata, 16'h0);
        chk("rst_d_rdata", d_rdata, 16'h0);
        mFree = 1; mStarve = 0; mInFlight = 0; mIR = '0; mDR = '0;
        pMemEn = 0; pIDone = 0; pDDone = 0; pDErr = 0; pChkWdata = 0;
        iActive = 0; dActive = 0; i_req = 0; d_req = 0;
        iQ.delete(); dQ.delete();
        if (rBusy) rStale = 1;
        rstHold = holdCycles;
    endtask

    function automatic bit quiet();
        return !iActive && !dActive && iQ.size() == 0 && dQ.size() == 0 && !rBusy &&
               mInFlight == 0 && mFree && !pIDone && !pDDone && rstHold == 0;
    endfunction

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (!quiet() && n < budget) begin
            tick();
            n++;
        end
        chk1({tag, "_drain"}, quiet(), 1'b1);
    endtask

    initial begin
        i_req = 0; d_req = 0; d_wr = 0; i_addr = '0; d_addr = '0; d_wdata = '0;
        mem_done = 0; mem_rdata = '0;
        rBusy = 0; rStale = 0; latFix = 0; rstHold = 0;
        for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
        mem[8] = 16'hA5A5;
        clearLogs();
        #2;
        doReset(3);

        // Fetch waiting as reset releases is granted at the first edge afterwards
        iQ.push_back(mk(16'h0010, 1'b0, 16'h0, 1'b0, 0));
        latFix = 2;
        drain("r37", 40);
        chk("r37_men_cnt", 16'(cntMemEn), 16'd1);
        chk("r37_addr", qAt(addrLog, 0), 16'h0010);
        chk("r37_idone_cnt", 16'(cntIDone), 16'd1);
        chk("r37_rdata", i_rdata, 16'hA5A5);

        clearLogs();
        latFix = 1;
        iQ.push_back(mk(16'h0020, 1'b0, 16'h0, 1'b0, 0));
        dQ.push_back(mk(16'h0100, 1'b0, 16'h0, 1'b0, 0));
        drain("r38", 40);
        chk("r38_first", qAt(addrLog, 0), 16'h0100);
        chk("r38_second", qAt(addrLog, 1), 16'h0020);
        chk("r38_done0_is_d", qAt(doneLog, 0), 16'd0);
        chk("r38_done1_is_i", qAt(doneLog, 1), 16'd1);
        chk("r31_min_latency", 16'(dDoneCycle - dRaiseCycle), 16'd3);

        clearLogs();
        for (int k = 0; k < 6; k++) dQ.push_back(mk(16'h0300 + 16'(2 * k), 1'b1, 16'(k), 1'b0, 0));
        iQ.push_back(mk(16'h0041, 1'b0, 16'h0, 1'b0, 0));
        drain("r39", 100);
        chk("r39_grants", 16'(wrLog.size()), 16'd7);
        for (int k = 0; k < 7; k++) chk("r39_kind", qAt(wrLog, k), (k == Limit) ? 16'd0 : 16'd1);
        chk("r39_i_addr", qAt(addrLog, Limit), 16'h0040);

        clearLogs();
        dQ.push_back(mk(16'h0101, 1'b1, 16'hBEEF, 1'b0, 0));
        drain("r40", 20);
        chk("r40_men_cnt", 16'(cntMemEn), 16'd0);
        chk("r40_ddone_cnt", 16'(cntDDone), 16'd1);
        chk("r40_derr_cnt", 16'(cntDErr), 16'd1);

        clearLogs();
        latFix = 3;
        dQ.push_back(mk(16'h0200, 1'b1, 16'h1234, 1'b0, 0));
        drain("r42", 30);
        chk("r42_wr", qAt(wrLog, 0), 16'd1);
        chk("r42_wdata", qAt(wdataLog, 0), 16'h1234);
        chk("r42_derr_cnt", 16'(cntDErr), 16'd0);
        chk("r42_ddone_cnt", 16'(cntDDone), 16'd1);
        dQ.push_back(mk(16'h0200, 1'b0, 16'h0, 1'b0, 0));
        drain("r42_load", 30);
        chk("r42_readback", d_rdata, 16'h1234);

        // Requesters dropping their request after the grant still get their done pulse
        clearLogs();
        latFix = 2;
        iQ.push_back(mk(16'h0050, 1'b0, 16'h0, 1'b1, 0));
        dQ.push_back(mk(16'h0060, 1'b1, 16'h5A5A, 1'b1, 0));
        drain("r29", 40);
        chk("r29_idone_cnt", 16'(cntIDone), 16'd1);
        chk("r29_ddone_cnt", 16'(cntDDone), 16'd1);

        // Reset while a load is in flight; its completion arrives after reset and must be ignored
        clearLogs();
        latFix = 8;
        dQ.push_back(mk(16'h0100, 1'b0, 16'h0, 1'b0, 0));
        begin
            int n = 0;
            while (cntMemEn == 0 && n < 20) begin tick(); n++; end
        end
        chk("r41_launched", 16'(cntMemEn), 16'd1);
        tick();
        doReset(2);
        begin
            int n = 0;
            while ((rBusy || rstHold != 0) && n < 30) begin tick(); n++; end
        end
        chk1("r41_stale_seen", rBusy, 1'b0);
        tick();
        chk("r41_no_ddone", 16'(cntDDone), 16'd0);
        latFix = 0;
        iQ.push_back(mk(16'h0030, 1'b0, 16'h0, 1'b0, 0));
        drain("r41_next", 30);
        chk("r41_idone_cnt", 16'(cntIDone), 16'd1);
        chk("r41_addr", qAt(addrLog, addrLog.size() - 1), 16'h0030);

        // Randomised traffic against the model
        latFix = 0;
        for (int k = 0; k < 200; k++) begin
            iQ.push_back(mk(16'($urandom), 1'b0, 16'h0, ($urandom_range(7, 0) == 0),
                            int'($urandom_range(3, 0))));
            dQ.push_back(mk({7'd0, 8'($urandom), 1'b0}, 1'($urandom), 16'($urandom),
                            ($urandom_range(7, 0) == 0), int'($urandom_range(2, 0))));
        end
        drain("random", 20000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
